// File: rtl/uart_rx_core_if.sv
// Parallel-side and serial-line signals of the UART receiver core.
// The core takes the slave view; whatever drives the line and configuration takes the master view.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      rx_in;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      par_en;
  logic                      par_typ;
  logic [DATA_WIDTH-1:0]     p_data;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start detect, 3-point mid-bit majority vote, LSB-first
// deserialisation, optional parity check, stop check and single-cycle result pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic           clk,
  input logic           rst,
  uart_rx_core_if.slave bus
);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
  localparam logic [BIT_W-1:0]          LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [PRESCALE_WIDTH-1:0] edge_cnt_reg;
  logic [PRESCALE_WIDTH-1:0] presc_reg;
  logic [PRESCALE_WIDTH-1:0] mid;
  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic [BIT_W-1:0]          bit_cnt_reg;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic [DATA_WIDTH:0]       shift_ext;
  logic [DATA_WIDTH-1:0]     p_data_reg;
  logic                      par_en_reg;
  logic                      par_typ_reg;
  logic                      par_bad_reg;
  logic                      data_valid_reg;
  logic                      par_err_reg;
  logic                      stp_err_reg;

  logic [2:0] samples;
  logic       bit_val;
  logic       end_of_bit;
  logic       last_data_bit;
  logic       exp_par;
  logic       start_det;
  logic       shift_en;
  logic       par_chk;
  logic       frame_done;

  assign mid           = presc_reg >> 1;
  assign last_edge     = presc_reg - ONE;
  assign end_of_bit    = (edge_cnt_reg == last_edge);
  assign last_data_bit = (bit_cnt_reg == LAST_BIT);
  assign bit_val       = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
  // Odd parity expects the complement of the data XOR.
  assign exp_par       = (^shift_reg) ^ par_typ_reg;
  assign shift_ext     = {bit_val, shift_reg};

  // Three sample points straddle mid-bit at P/2-1, P/2 and P/2+1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sample
      localparam logic [PRESCALE_WIDTH-1:0] OFS = PRESCALE_WIDTH'(gi);
      logic sample_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sample_reg <= 1'b0;
        end else if (state_reg != IDLE && edge_cnt_reg == (mid - ONE + OFS)) begin
          sample_reg <= bus.rx_in;
        end
      end

      assign samples[gi] = sample_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!bus.rx_in) state_next = START;
      START:   if (end_of_bit) state_next = bit_val ? IDLE : DATA;
      DATA:    if (end_of_bit && last_data_bit) state_next = par_en_reg ? PARITY : STOP;
      PARITY:  if (end_of_bit) state_next = STOP;
      STOP:    if (end_of_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE:    start_det  = !bus.rx_in;
      DATA:    shift_en   = end_of_bit;
      PARITY:  par_chk    = end_of_bit;
      STOP:    frame_done = end_of_bit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else begin
      if (state_reg == IDLE || end_of_bit) begin
        edge_cnt_reg <= '0;
      end else begin
        edge_cnt_reg <= edge_cnt_reg + ONE;
      end

      if (state_reg != DATA) begin
        bit_cnt_reg <= '0;
      end else if (shift_en) begin
        bit_cnt_reg <= last_data_bit ? '0 : bit_cnt_reg + BIT_W'(1);
      end
    end
  end

  // Configuration is frozen for the whole frame at the moment the start edge is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg   <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      shift_reg   <= '0;
      par_bad_reg <= 1'b0;
    end else begin
      if (start_det) begin
        presc_reg   <= bus.prescale;
        par_en_reg  <= bus.par_en;
        par_typ_reg <= bus.par_typ;
        shift_reg   <= '0;
        par_bad_reg <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= shift_ext[DATA_WIDTH:1];
      end
      if (par_chk) begin
        par_bad_reg <= (bit_val != exp_par);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data_reg     <= '0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
      if (frame_done) begin
        stp_err_reg    <= ~bit_val;
        par_err_reg    <= par_bad_reg;
        data_valid_reg <= bit_val & ~par_bad_reg;
        if (bit_val && !par_bad_reg) begin
          p_data_reg <= shift_reg;
        end
      end
    end
  end

  assign bus.p_data     = p_data_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.par_err    = par_err_reg;
  assign bus.stp_err    = stp_err_reg;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: serial frames built from bit lists, expected pulse cycle,
// flags and held word computed from frame rules, compared against a pulse log.
module tb_uart_rx_core;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: cycle count at the negedge where a pulse is visible, {dv,pe,se}, p_data.
  int         obs_cyc[$];
  logic [2:0] obs_flags[$];
  logic [7:0] obs_data[$];

  always @(negedge clk) begin
    if (bus.data_valid || bus.par_err || bus.stp_err) begin
      obs_cyc.push_back(cyc);
      obs_flags.push_back({bus.data_valid, bus.par_err, bus.stp_err});
      obs_data.push_back(bus.p_data);
    end
  end

  int         vectors     = 0;
  int         miscompares = 0;
  int         rd_idx      = 0;
  int         idle_from   = 0;
  logic [7:0] model_pdata = 8'h00;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model_flags(input logic [7:0] data, input logic pen, input logic ptyp,
                                             input logic pbit, input logic stop_bit);
    logic pe, se;
    pe = pen && ((($countones(data) + int'(pbit)) % 2) != int'(ptyp));
    se = !stop_bit;
    return {!pe && !se, pe, se};
  endfunction

  task automatic drive_bit(input logic v, input int p, input int glitch_k);
    for (int k = 0; k < p; k++) begin
      bus.rx_in = (k == glitch_k) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Returns the edge at which the receiver is expected to see the start bit.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen, input logic ptyp,
                            input logic pbit, input logic stop_bit, input int glitch_bit, output int sd);
    int legal[3] = '{8, 16, 32};
    bus.prescale = 6'(p);
    bus.par_en   = pen;
    bus.par_typ  = ptyp;
    sd = (cyc + 1 > idle_from) ? cyc + 1 : idle_from;
    idle_from = sd + (pen ? 11 : 10) * p + 1;
    drive_bit(1'b0, p, -1);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        bus.prescale = 6'(legal[$urandom_range(0, 2)]);
        bus.par_en   = 1'($urandom);
        bus.par_typ  = 1'($urandom);
      end
      drive_bit(data[i], p, (i == glitch_bit) ? p / 2 + 1 : -1);
    end
    if (pen) drive_bit(pbit, p, -1);
    drive_bit(stop_bit, p, -1);
    bus.rx_in = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs %h, expected 0", {bus.p_data, bus.data_valid, bus.par_err, bus.stp_err});
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_release: outputs %h, expected 0", {bus.p_data, bus.data_valid, bus.par_err, bus.stp_err});
    end
    rd_idx = obs_cyc.size();
  endtask

  task automatic test_single(input string name, input logic [7:0] data, input int p, input logic pen,
                             input logic ptyp, input logic pbit, input logic stop_bit, input int glitch_bit);
    int         sd, rel_exp;
    logic [2:0] fl_exp;
    send_frame(data, p, pen, ptyp, pbit, stop_bit, glitch_bit, sd);
    repeat (4) @(negedge clk);
    fl_exp  = model_flags(data, pen, ptyp, pbit, stop_bit);
    if (fl_exp[2]) model_pdata = data;
    rel_exp = (pen ? 11 : 10) * p + 1;
    vectors++;
    if (obs_cyc.size() !== rd_idx + 1) begin
      miscompares++;
      $display("FAIL %s_count: %0d pulses, expected 1", name, obs_cyc.size() - rd_idx);
    end else begin
      vectors++;
      if (obs_cyc[rd_idx] - sd + 1 !== rel_exp) begin
        miscompares++;
        $display("FAIL %s_cycle: pulse at cycle %0d, expected %0d", name, obs_cyc[rd_idx] - sd + 1, rel_exp);
      end
      vectors++;
      if (obs_flags[rd_idx] !== fl_exp) begin
        miscompares++;
        $display("FAIL %s_flags: {dv,pe,se}=%b, expected %b", name, obs_flags[rd_idx], fl_exp);
      end
      vectors++;
      if (obs_data[rd_idx] !== model_pdata) begin
        miscompares++;
        $display("FAIL %s_data: p_data=%h, expected %h", name, obs_data[rd_idx], model_pdata);
      end
    end
    rd_idx = obs_cyc.size();
    $display("frame %s: data=%h P=%0d par_en=%0b -> flags %b p_data %h", name, data, p, pen, fl_exp, model_pdata);
  endtask

  task automatic test_parity_and_stop;
    test_single("even_par", 8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    test_single("no_par", 8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    test_single("par_err", 8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    test_single("odd_par", 8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    test_single("stop_err", 8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    vectors++;
    if (bus.p_data !== 8'h01) begin
      miscompares++;
      $display("FAIL stop_err_hold: p_data=%h, expected 01", bus.p_data);
    end
  endtask

  task automatic test_start_glitch;
    int s;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    s = cyc + 1;
    bus.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_in = 1'b1;
    while (cyc < s + 8) @(negedge clk);
    // Receiver must be idle again by cycle P+1; a frame starting exactly there is timed from it.
    idle_from = s + 9;
    test_single("after_glitch", 8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    test_single("data_glitch", 8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3);
  endtask

  task automatic test_back_to_back;
    int         sd[2];
    logic [7:0] words[2] = '{8'h11, 8'h22};
    send_frame(words[0], 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, sd[0]);
    send_frame(words[1], 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, sd[1]);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_cyc.size() !== rd_idx + 2) begin
      miscompares++;
      $display("FAIL b2b_count: %0d pulses, expected 2", obs_cyc.size() - rd_idx);
    end else begin
      for (int e = 0; e < 2; e++) begin
        vectors++;
        if (obs_cyc[rd_idx + e] - sd[e] + 1 !== 89 || obs_flags[rd_idx + e] !== 3'b100 ||
            obs_data[rd_idx + e] !== words[e]) begin
          miscompares++;
          $display("FAIL b2b_frame%0d: cycle %0d flags %b data %h, expected cycle 89 flags 100 data %h",
                   e, obs_cyc[rd_idx + e] - sd[e] + 1, obs_flags[rd_idx + e], obs_data[rd_idx + e], words[e]);
        end
      end
    end
    rd_idx = obs_cyc.size();
    model_pdata = 8'h22;
    $display("frame b2b: 11 then 22 P=8 even parity");
  endtask

  task automatic test_reset_mid_frame;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b1;
    bus.par_typ  = 1'b0;
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b1, 8, -1);
    bus.rx_in = 1'b1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: outputs %h, expected 0", {bus.p_data, bus.data_valid, bus.par_err, bus.stp_err});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_from   = 0;
    model_pdata = 8'h00;
    repeat (100) @(negedge clk);
    vectors++;
    if (obs_cyc.size() !== rd_idx) begin
      miscompares++;
      $display("FAIL midframe_nopulse: %0d pulses, expected 0", obs_cyc.size() - rd_idx);
    end
    rd_idx = obs_cyc.size();
    $display("frame reset_mid: dropped, outputs cleared");
    test_single("after_reset", 8'h33, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_random;
    int         legal[3] = '{8, 16, 32};
    int         exp_cyc[$];
    logic [2:0] exp_flags[$];
    logic [7:0] exp_data[$];
    int         sd, p, gap, n;
    logic [7:0] data;
    logic       pen, ptyp, pbit, stop_bit;
    logic [2:0] fl;
    for (int f = 0; f < 40; f++) begin
      p        = legal[$urandom_range(0, 2)];
      data     = 8'($urandom);
      pen      = 1'($urandom);
      ptyp     = 1'($urandom);
      pbit     = 1'(($countones(data) + int'(ptyp)) % 2);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stop_bit = ($urandom_range(0, 9) != 0);
      send_frame(data, p, pen, ptyp, pbit, stop_bit, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1, sd);
      fl = model_flags(data, pen, ptyp, pbit, stop_bit);
      if (fl[2]) model_pdata = data;
      exp_cyc.push_back(sd + (pen ? 11 : 10) * p);
      exp_flags.push_back(fl);
      exp_data.push_back(model_pdata);
      $display("frame rand%0d: data=%h P=%0d par_en=%0b par_typ=%0b pbit=%0b stop=%0b -> flags %b",
               f, data, p, pen, ptyp, pbit, stop_bit, fl);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n = exp_cyc.size();
    vectors++;
    if (obs_cyc.size() - rd_idx !== n) begin
      miscompares++;
      $display("FAIL rand_count: %0d pulses, expected %0d", obs_cyc.size() - rd_idx, n);
    end
    for (int e = 0; e < n; e++) begin
      if (rd_idx + e < obs_cyc.size()) begin
        vectors++;
        if (obs_cyc[rd_idx + e] !== exp_cyc[e] || obs_flags[rd_idx + e] !== exp_flags[e] ||
            obs_data[rd_idx + e] !== exp_data[e]) begin
          miscompares++;
          $display("FAIL rand_frame%0d: cyc %0d flags %b data %h, expected cyc %0d flags %b data %h",
                   e, obs_cyc[rd_idx + e], obs_flags[rd_idx + e], obs_data[rd_idx + e],
                   exp_cyc[e], exp_flags[e], exp_data[e]);
        end
      end
    end
    rd_idx = obs_cyc.size();
  endtask

  initial begin
    bus.rx_in    = 1'b1;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;
    test_reset();
    test_parity_and_stop();
    repeat (5) @(negedge clk);
    test_start_glitch();
    repeat (5) @(negedge clk);
    test_back_to_back();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
